// File: rtl/namco06xx_dev_responder_if.sv
// Shared I/O device bus as seen by the 06XX responder: address, strobes,
// write data, and the registered read-data return path.
interface namco06xx_dev_responder_if;
  logic [15:0] DEV_AD;
  logic        DEV_RD;
  logic        DEV_WR;
  logic [7:0]  DEV_DI;
  logic        DEV_DV;
  logic [7:0]  DEV_DO;

  modport master (
    output DEV_AD, DEV_RD, DEV_WR, DEV_DI,
    input  DEV_DV, DEV_DO
  );

  modport slave (
    input  DEV_AD, DEV_RD, DEV_WR, DEV_DI,
    output DEV_DV, DEV_DO
  );
endinterface

// File: rtl/namco06xx_dev_responder.sv
// Namco 06XX window responder: CTRL/DATA register decode, 51XX input
// sequence (INP0, INP1, DSW0), and the NMI timer pacing 06XX transfers.
module namco06xx_dev_responder #(
  parameter logic [15:0] BASE = 16'h7000,
  parameter int          TICK = 4800
) (
  input  logic                          CL,
  input  logic                          RESET,
  namco06xx_dev_responder_if.slave      dev,
  input  logic [7:0]                    INP0,
  input  logic [7:0]                    INP1,
  input  logic [7:0]                    DSW0,
  output logic                          NMI
);

  localparam logic [15:0] PRE_LAST = 16'(TICK - 1);

  logic [7:0]  ctrl_reg;
  logic [1:0]  idx_reg;
  logic [15:0] pre_reg;
  logic [2:0]  mul_reg;
  logic        dv_reg;
  logic [7:0]  do_reg;
  logic        nmi_reg;

  logic       data_hit, ctrl_hit;
  logic       ctrl_wr, data_wr, rd_ok;
  logic       seq_rd, seq_restart, pre_wrap;
  logic [2:0] rate;
  logic [7:0] seq_bytes [3];
  logic [7:0] seq_byte;
  logic [7:0] rd_data;

  assign data_hit = (dev.DEV_AD == BASE);
  assign ctrl_hit = (dev.DEV_AD == BASE + 16'h0100);
  assign ctrl_wr  = dev.DEV_WR && ctrl_hit;
  assign data_wr  = dev.DEV_WR && data_hit;
  // A write in the same cycle swallows the read completely.
  assign rd_ok    = dev.DEV_RD && !dev.DEV_WR && (data_hit || ctrl_hit);

  assign seq_rd      = ctrl_reg[0] && ctrl_reg[4];
  assign seq_restart = data_wr && ctrl_reg[0] && !ctrl_reg[4] && (dev.DEV_DI == 8'h01);
  assign rate        = ctrl_reg[7:5];
  assign pre_wrap    = (pre_reg == PRE_LAST);

  assign seq_bytes[0] = INP0;
  assign seq_bytes[1] = INP1;
  assign seq_bytes[2] = DSW0;

  always_comb begin
    seq_byte = seq_bytes[0];
    if (idx_reg == 2'd1) seq_byte = seq_bytes[1];
    if (idx_reg == 2'd2) seq_byte = seq_bytes[2];
  end

  always_comb begin
    rd_data = 8'hFF;
    if (ctrl_hit)    rd_data = ctrl_reg;
    else if (seq_rd) rd_data = seq_byte;
  end

  always_ff @(posedge CL or posedge RESET) begin
    if (RESET) begin
      ctrl_reg <= 8'h00;
      idx_reg  <= 2'd0;
      pre_reg  <= 16'd0;
      mul_reg  <= 3'd0;
      dv_reg   <= 1'b0;
      do_reg   <= 8'h00;
      nmi_reg  <= 1'b0;
    end else begin
      dv_reg  <= rd_ok;
      nmi_reg <= 1'b0;
      if (rd_ok)
        do_reg <= rd_data;

      if (ctrl_wr) begin
        // A CTRL write restarts the timer even on a prescaler wrap edge.
        ctrl_reg <= dev.DEV_DI;
        idx_reg  <= 2'd0;
        pre_reg  <= 16'd0;
        mul_reg  <= 3'd0;
      end else begin
        if (seq_restart)
          idx_reg <= 2'd0;
        else if (rd_ok && data_hit && seq_rd)
          idx_reg <= (idx_reg == 2'd2) ? 2'd0 : idx_reg + 2'd1;

        if (rate == 3'd0) begin
          pre_reg <= 16'd0;
          mul_reg <= 3'd0;
        end else if (pre_wrap) begin
          pre_reg <= 16'd0;
          if (mul_reg == rate - 3'd1) begin
            nmi_reg <= 1'b1;
            mul_reg <= 3'd0;
          end else begin
            mul_reg <= mul_reg + 3'd1;
          end
        end else begin
          pre_reg <= pre_reg + 16'd1;
        end
      end
    end
  end

  assign dev.DEV_DV = dv_reg;
  assign dev.DEV_DO = do_reg;
  assign NMI        = nmi_reg;

endmodule

// File: tb/tb_namco06xx_dev_responder.sv
// Directed bench for the 06XX responder: register decode, input sequence,
// NMI timing with a short prescaler, read/write collision and async reset.
module tb_namco06xx_dev_responder;
  localparam logic [15:0] BASE  = 16'h7000;
  localparam logic [15:0] CTRLA = 16'h7100;
  localparam int          TICK  = 8;

  logic       CL = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] INP0 = 8'hA5;
  logic [7:0] INP1 = 8'h3C;
  logic [7:0] DSW0 = 8'h81;
  logic       NMI;

  int checks = 0;
  int errors = 0;

  namco06xx_dev_responder_if bus ();

  namco06xx_dev_responder #(.BASE(BASE), .TICK(TICK)) dut (
    .CL   (CL),
    .RESET(RESET),
    .dev  (bus.slave),
    .INP0 (INP0),
    .INP1 (INP1),
    .DSW0 (DSW0),
    .NMI  (NMI)
  );

  always #5 CL = ~CL;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_read(input logic [15:0] addr, output logic dv, output logic [7:0] d);
    @(negedge CL);
    bus.DEV_AD = addr;
    bus.DEV_RD = 1'b1;
    @(posedge CL);
    #1;
    bus.DEV_RD = 1'b0;
    dv = bus.DEV_DV;
    d  = bus.DEV_DO;
    $display("rd %h -> dv %b do %h", addr, dv, d);
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [7:0] d);
    @(negedge CL);
    bus.DEV_AD = addr;
    bus.DEV_DI = d;
    bus.DEV_WR = 1'b1;
    @(posedge CL);
    #1;
    bus.DEV_WR = 1'b0;
    $display("wr %h <- %h", addr, d);
  endtask

  // Counts NMI-high cycles over n edges, recording the first two pulse positions.
  task automatic watch_nmi(input int n, output int cnt, output int first, output int second);
    cnt = 0; first = -1; second = -1;
    for (int k = 1; k <= n; k++) begin
      @(posedge CL);
      #1;
      if (NMI) begin
        cnt++;
        if (first < 0) first = k;
        else if (second < 0) second = k;
      end
    end
    $display("nmi watch %0d cycles: high %0d first %0d second %0d", n, cnt, first, second);
  endtask

  initial begin
    logic       dv;
    logic [7:0] d;
    int         cnt, first, second;
    bit         seen;

    bus.DEV_AD = 16'h0000;
    bus.DEV_RD = 1'b0;
    bus.DEV_WR = 1'b0;
    bus.DEV_DI = 8'h00;

    repeat (3) @(posedge CL);
    #1;
    check_eq("rst_dv", 16'(bus.DEV_DV), 16'h0);
    check_eq("rst_do", 16'(bus.DEV_DO), 16'h00);
    check_eq("rst_nmi", 16'(NMI), 16'h0);
    @(negedge CL);
    RESET = 1'b0;

    bus_read(CTRLA, dv, d);
    check_eq("ctrl_rd_dv", 16'(dv), 16'h1);
    check_eq("ctrl_rd_do", 16'(d), 16'h00);
    @(posedge CL); #1;
    check_eq("dv_drop", 16'(bus.DEV_DV), 16'h0);
    check_eq("do_hold", 16'(bus.DEV_DO), 16'h00);
    watch_nmi(10 * TICK, cnt, first, second);
    check_eq("nmi_idle", 16'(cnt), 16'd0);

    // Input sequence wraps after DSW0.
    bus_write(CTRLA, 8'h11);
    bus_read(BASE, dv, d); check_eq("seq0", 16'(d), 16'hA5);
    check_eq("seq0_dv", 16'(dv), 16'h1);
    bus_read(BASE, dv, d); check_eq("seq1", 16'(d), 16'h3C);
    bus_read(BASE, dv, d); check_eq("seq2", 16'(d), 16'h81);
    bus_read(BASE, dv, d); check_eq("seq3", 16'(d), 16'hA5);

    bus_write(CTRLA, 8'h11);
    bus_read(BASE, dv, d); check_eq("rs_first", 16'(d), 16'hA5);
    bus_write(CTRLA, 8'h01);
    bus_write(BASE, 8'h01);
    bus_write(CTRLA, 8'h11);
    bus_read(BASE, dv, d); check_eq("rs_restart", 16'(d), 16'hA5);
    bus_write(CTRLA, 8'h02);
    bus_read(BASE, dv, d); check_eq("no_sel_ff", 16'(d), 16'hFF);
    check_eq("no_sel_dv", 16'(dv), 16'h1);

    // R=3, TICK=8: pulses at 24, 48, 72 cycles after the write edge.
    bus_write(CTRLA, 8'h71);
    watch_nmi(80, cnt, first, second);
    check_eq("nmi_first", 16'(first), 16'd24);
    check_eq("nmi_second", 16'(second), 16'd48);
    check_eq("nmi_count", 16'(cnt), 16'd3);
    bus_write(CTRLA, 8'h11);
    watch_nmi(80, cnt, first, second);
    check_eq("nmi_stop", 16'(cnt), 16'd0);

    // Read and write together: write lands, read is dropped.
    @(negedge CL);
    bus.DEV_AD = CTRLA; bus.DEV_DI = 8'h31;
    bus.DEV_RD = 1'b1;  bus.DEV_WR = 1'b1;
    @(posedge CL); #1;
    bus.DEV_RD = 1'b0;  bus.DEV_WR = 1'b0;
    $display("rd+wr %h <- %h dv %b", CTRLA, 8'h31, bus.DEV_DV);
    check_eq("rdwr_dv", 16'(bus.DEV_DV), 16'h0);
    bus_read(CTRLA, dv, d); check_eq("rdwr_ctrl", 16'(d), 16'h31);
    bus_read(16'h7001, dv, d); check_eq("miss_dv", 16'(dv), 16'h0);

    // R=7, IDX=2, then hold a CTRL read until NMI fires and reset mid-cycle.
    bus_write(CTRLA, 8'hF1);
    bus_read(BASE, dv, d); check_eq("pre_rst0", 16'(d), 16'hA5);
    bus_read(BASE, dv, d); check_eq("pre_rst1", 16'(d), 16'h3C);
    @(negedge CL);
    bus.DEV_AD = CTRLA; bus.DEV_RD = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(posedge CL); #1;
      if (NMI) seen = 1'b1;
    end
    check_eq("nmi_r7_seen", 16'(seen), 16'h1);
    check_eq("nmi_r7_dv", 16'(bus.DEV_DV), 16'h1);
    #1 RESET = 1'b1;
    #1;
    $display("async reset asserted");
    check_eq("arst_nmi", 16'(NMI), 16'h0);
    check_eq("arst_dv", 16'(bus.DEV_DV), 16'h0);
    check_eq("arst_do", 16'(bus.DEV_DO), 16'h00);
    bus.DEV_RD = 1'b0;
    repeat (2) @(posedge CL);
    @(negedge CL);
    RESET = 1'b0;
    bus_read(CTRLA, dv, d);
    check_eq("post_rst_dv", 16'(dv), 16'h1);
    check_eq("post_rst_ctrl", 16'(d), 16'h00);
    bus_write(CTRLA, 8'h11);
    bus_read(BASE, dv, d); check_eq("post_rst_seq", 16'(d), 16'hA5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end
endmodule
